syn_fifo_reader: RTL and testbench

Read-side consumer for the synchronous FIFO. It pops the FIFO read port, absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer, and presents the words as a valid/ready stream to downstream logic at full throughput. It also supports a flush that drains and discards the FIFO contents. It sits between `syn_fifo` and any streaming consumer.

---
 rtl/syn_fifo_pkg.sv | 19 +
 rtl/syn_fifo_reader_buf.sv | 52 +++++
 rtl/syn_fifo_reader.sv | 114 +++++++++++
 tb/tb_syn_fifo_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/syn_fifo_pkg.sv
// Shared types and constants for the synchronous FIFO and its read-side consumer.
package syn_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } reader_state_e;

    localparam int READER_BUF_DEPTH = 3;
    localparam int READER_PTR_W     = 2;
    localparam int READER_OCC_W     = 2;

    // Circular pointer advance for the non-power-of-two reader buffer.
    function automatic logic [READER_PTR_W-1:0] reader_ptr_inc(input logic [READER_PTR_W-1:0] p);
        return (p == READER_PTR_W'(READER_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/syn_fifo_reader_buf.sv
// 3-entry circular skid buffer that absorbs the FIFO's registered read latency.
module syn_fifo_reader_buf
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    pop,
    input  logic                    clr,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic [READER_OCC_W-1:0] occ
);

    logic [DATA_WIDTH-1:0]   mem [READER_BUF_DEPTH];
    logic [READER_PTR_W-1:0] rd_ptr;
    logic [READER_PTR_W-1:0] wr_ptr;
    logic [READER_OCC_W-1:0] occ_q;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= reader_ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= reader_ptr_inc(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign occ       = occ_q;

endmodule

// File: rtl/syn_fifo_reader.sv
// Read-side consumer for syn_fifo: pops the FIFO, buffers returned words and
// presents them as a full-throughput valid/ready stream, with a draining flush.
module syn_fifo_reader
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
    output logic                  busy_o,
    output logic                  flush_done_o,
    output reader_state_e         dbg_state_o
);

    // Stream handshake: a beat transfers on a rising edge where m_valid_o and
    // m_ready_i are both high; m_valid_o never depends on m_ready_i, and
    // m_ready_i never reaches fifo_rd_o combinationally.

    reader_state_e           state_q;
    reader_state_e           state_d;
    logic                    inflight_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [READER_OCC_W-1:0] occ;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [2:0]              occ_sum;
    logic                    can_pop;
    logic                    hs;
    logic                    buf_wr;
    logic                    rd;
    logic                    done;

    assign occ_sum = {1'b0, occ} + {2'b00, inflight_q};
    assign can_pop = (occ_sum <= 3'd2);
    assign hs      = m_valid_o & m_ready_i;
    // Words returned while flushing (or in the flush cycle itself) are dropped.
    assign buf_wr  = inflight_q & (state_q == STREAM) & ~flush_i;

    always_comb begin
        state_d = state_q;
        rd      = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (enable_i) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                rd = enable_i & ~fifo_empty_i & can_pop;
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (!enable_i && occ == '0 && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                rd = ~fifo_empty_i;
                if (!flush_i && fifo_empty_i && !inflight_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd;
            if (hs) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    syn_fifo_reader_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (sys_clk_i),
        .rst      (sys_rst_i),
        .wr_en    (buf_wr),
        .wr_data  (fifo_data_i),
        .pop      (hs & ~flush_i),
        .clr      (flush_i),
        .head_data(head_data),
        .occ      (occ)
    );

    assign fifo_rd_o    = rd;
    assign m_valid_o    = (occ != '0);
    assign m_data_o     = m_valid_o ? head_data : '0;
    assign xfer_cnt_o   = cnt_q;
    assign busy_o       = (state_q != IDLE);
    assign flush_done_o = done;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_syn_fifo_reader.sv
// Bench for syn_fifo_reader: a queue-based FIFO source and an in-order
// scoreboard of loaded words; a second instance with a 4-bit counter runs in lockstep.
module tb_syn_fifo_reader;
    import syn_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst, enable, flush, fifo_empty, m_ready;
    logic [7:0] fifo_data;

    logic rd_a, valid_a, busy_a, done_a;
    logic [7:0] data_a;
    logic [15:0] cnt_a;
    reader_state_e state_a;
    logic rd_b, valid_b, busy_b, done_b;
    logic [7:0] data_b;
    logic [3:0] cnt_b;
    reader_state_e state_b;

    syn_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut_a (
        .sys_clk_i(clk), .sys_rst_i(rst), .enable_i(enable), .flush_i(flush),
        .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_rd_o(rd_a),
        .m_valid_o(valid_a), .m_data_o(data_a), .m_ready_i(m_ready),
        .xfer_cnt_o(cnt_a), .busy_o(busy_a), .flush_done_o(done_a), .dbg_state_o(state_a)
    );

    syn_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut_b (
        .sys_clk_i(clk), .sys_rst_i(rst), .enable_i(enable), .flush_i(flush),
        .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_rd_o(rd_b),
        .m_valid_o(valid_b), .m_data_o(data_b), .m_ready_i(m_ready),
        .xfer_cnt_o(cnt_b), .busy_o(busy_b), .flush_done_o(done_b), .dbg_state_o(state_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [31:0] hs_cnt = 0;
    int cyc = 0;
    int first_rd, first_valid, first_hs, last_hs, n_hs, pop_cnt, done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_marks();
        first_rd = -1; first_valid = -1; first_hs = -1; last_hs = -1;
        n_hs = 0; pop_cnt = 0; done_cnt = 0;
    endtask

    // One clock: observe at the falling edge, then update the FIFO model
    // just after the rising edge from the pop seen in that cycle.
    task automatic step();
        logic rd_seen, rst_seen;
        logic [7:0] e;
        @(negedge clk);
        rd_seen  = (rd_a === 1'b1);
        rst_seen = rst;
        if (!rst) begin
            check_eq("cnt_a", {16'h0, cnt_a}, {16'h0, hs_cnt[15:0]});
            check_eq("cnt_b", {28'h0, cnt_b}, {28'h0, hs_cnt[3:0]});
            check_eq("rd_on_empty", {31'h0, (rd_a | rd_b) & fifo_empty}, 32'h0);
            if (rd_a && first_rd < 0) first_rd = cyc;
            if (valid_a && first_valid < 0) first_valid = cyc;
            if (done_a || done_b) done_cnt++;
            if (valid_a && m_ready) begin
                check_eq("beat_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("beat_data_a", {24'h0, data_a}, {24'h0, e});
                    check_eq("beat_data_b", {23'h0, valid_b, data_b}, {23'h0, 1'b1, e});
                end
                hs_cnt++;
                n_hs++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
        end
        if (rd_seen) pop_cnt++;
        cyc++;
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        if (rst_seen) begin
            exp_q  = fifo_q;
            hs_cnt = 0;
        end
    endtask

    task automatic load(input int n, input bit random_data, input logic [7:0] base);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            w = random_data ? 8'($urandom_range(0, 255)) : base + 8'(i);
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_a"}, {12'h0, rd_a, valid_a, data_a, busy_a, done_a, 6'h0, 2'(state_a)}, 32'h0);
        check_eq({tag, "_b"}, {12'h0, rd_b, valid_b, data_b, busy_b, done_b, 6'h0, 2'(state_b)}, 32'h0);
        check_eq({tag, "_cnt"}, {12'h0, cnt_b, cnt_a}, 32'h0);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check_eq(tag, exp_q.size(), 32'h0);
    endtask

    // Pulse flush, discard everything undelivered, wait for the single done pulse.
    task automatic do_flush();
        logic [31:0] cnt_before;
        flush = 1'b1;
        #1;
        check_eq("done_in_flush_cycle", {31'h0, done_a | done_b}, 32'h0);
        done_cnt = 0;
        step();
        flush = 1'b0;
        exp_q.delete();
        cnt_before = hs_cnt;
        check_eq("valid_after_flush", {30'h0, valid_a, valid_b}, 32'h0);
        for (int i = 0; i < 60 && done_cnt == 0; i++) step();
        for (int i = 0; i < 3; i++) step();
        check_eq("flush_done_pulses", done_cnt, 32'h1);
        check_eq("fifo_drained", {31'h0, fifo_empty}, 32'h1);
        check_eq("cnt_after_flush", hs_cnt, cnt_before);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_data = 8'h00;
        clear_marks();

        // Reset, then enabled with an empty FIFO for 20 cycles.
        do_reset();
        do_reset();
        check_idle_outputs("reset");
        enable = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check_eq("empty_run_pops", pop_cnt, 32'h0);
        check_eq("empty_run_out", {29'h0, valid_a, busy_a, busy_b}, 32'h3);

        // 16 preloaded words, ready held high.
        clear_marks();
        m_ready = 1'b1;
        load(16, 1'b0, 8'h00);
        drain("drain_full_rate", 100);
        check_eq("first_latency", first_valid - first_rd, 32'h2);
        check_eq("full_rate_beats", n_hs, 32'd16);
        check_eq("full_rate_span", last_hs - first_hs, 32'd15);
        check_eq("cnt_16", {16'h0, cnt_a}, 32'd16);
        enable = 1'b0;
        for (int i = 0; i < 10 && busy_a; i++) step();
        check_eq("idle_after_disable", {30'h0, busy_a, busy_b}, 32'h0);

        // Backpressure: only three pops complete, head held stable.
        clear_marks();
        m_ready = 1'b0;
        load(16, 1'b0, 8'h00);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_a) check_eq("stall_head", {24'h0, data_a}, 32'h00);
        end
        check_eq("stall_pops", pop_cnt, 32'h3);
        check_eq("stall_valid", {31'h0, valid_a}, 32'h1);
        clear_marks();
        m_ready = 1'b1;
        drain("drain_after_stall", 100);
        check_eq("stall_release_beats", n_hs, 32'd16);
        check_eq("stall_release_gap_ok", {31'h0, (last_hs - first_hs) <= 16}, 32'h1);

        // Flush in the middle of an 8-word stream with random ready.
        load(8, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        enable = 1'b0;
        do_flush();
        check_eq("idle_after_flush", {30'h0, busy_a, busy_b}, 32'h0);

        // Flush with the FIFO already empty.
        do_flush();

        // Reset pulse mid-stream: delivery resumes from the FIFO head.
        enable = 1'b1;
        load(10, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        do_reset();
        check_idle_outputs("mid_reset");
        m_ready = 1'b1;
        drain("drain_after_reset", 100);

        // Random traffic with occasional disable and flush.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 24) load($urandom_range(1, 3), 1'b1, 8'h00);
            m_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 79) == 0) do_flush();
            else step();
        end
        enable = 1'b1;
        m_ready = 1'b1;
        drain("drain_random", 200);

        // 4-bit counter wrap after 17 transfers.
        do_reset();
        load(17, 1'b1, 8'h00);
        drain("drain_wrap", 100);
        step();
        check_eq("cnt_wrap_b", {28'h0, cnt_b}, 32'h1);
        check_eq("cnt_wrap_a", {16'h0, cnt_a}, 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
